wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/core_pkg.sv | 28 ++
 rtl/wb_arbiter_rr_pick2.sv | 39 +++
 rtl/wb_arbiter.sv | 170 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// core_pkg -- shared widths, requester indices and helpers for wb_arbiter
// Revision: 1.0
// ============================================================================
package core_pkg;

  localparam int WIDTH_PRD_DFLT  = 7;
  localparam int WIDTH_BRM_DFLT  = 3;
  localparam int WIDTH_DATA_DFLT = 32;
  localparam int NUM_REQ         = 4;

  localparam logic [1:0] REQ_MEM  = 2'd0;
  localparam logic [1:0] REQ_ALU0 = 2'd1;
  localparam logic [1:0] REQ_ALU1 = 2'd2;
  localparam logic [1:0] REQ_BR   = 2'd3;

  function automatic logic [1:0] onehot4_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// rr_pick2 -- picks up to two requests in round-robin order starting at i_ptr
// Revision: 1.0
// ============================================================================
module rr_pick2 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [3:0] o_gnt0,
  output logic [3:0] o_gnt1,
  output logic       o_vld0,
  output logic       o_vld1
);

  logic [1:0] idx;

  // Search wraps naturally through the 2-bit add.
  always_comb begin
    o_gnt0 = 4'b0000;
    o_gnt1 = 4'b0000;
    o_vld0 = 1'b0;
    o_vld1 = 1'b0;
    idx    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = i_ptr + 2'(i);
      if (i_req[idx]) begin
        if (!o_vld0) begin
          o_gnt0[idx] = 1'b1;
          o_vld0      = 1'b1;
        end else if (!o_vld1) begin
          o_gnt1[idx] = 1'b1;
          o_vld1      = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// wb_arbiter -- 4-requester to 2-port regfile writeback arbiter with buffers.
// Optional branch-kill support: define WB_ARBITER_KILL_EN.   Revision: 1.0
// ============================================================================
module wb_arbiter
  import core_pkg::*;
#(
  parameter int WIDTH_PRD  = WIDTH_PRD_DFLT,
  parameter int WIDTH_BRM  = WIDTH_BRM_DFLT,
  parameter int WIDTH_DATA = WIDTH_DATA_DFLT
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [3:0]              i_req_valid,
  input  logic [4*WIDTH_PRD-1:0]  i_req_prd,
  input  logic [4*WIDTH_DATA-1:0] i_req_data,
  input  logic [4*WIDTH_BRM-1:0]  i_req_brmask,
  output logic [3:0]              o_req_ready,
  input  logic [WIDTH_BRM:0]      i_kill,
  output logic [1:0]              o_we,
  output logic [2*WIDTH_PRD-1:0]  o_waddr,
  output logic [2*WIDTH_DATA-1:0] o_wdata,
  output logic [2*WIDTH_PRD-1:0]  o_wdest2x,
  output logic                    o_busy
);

  logic [3:0]            buf_valid_q, buf_valid_d;
  logic [WIDTH_PRD-1:0]  buf_prd_q  [4];
  logic [WIDTH_PRD-1:0]  buf_prd_d  [4];
  logic [WIDTH_DATA-1:0] buf_data_q [4];
  logic [WIDTH_DATA-1:0] buf_data_d [4];
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic [1:0]            we_q, we_d;
  logic [2*WIDTH_PRD-1:0]  waddr_q, waddr_d;
  logic [2*WIDTH_DATA-1:0] wdata_q, wdata_d;
  logic [2*WIDTH_PRD-1:0]  wdest_q, wdest_d;

  logic [3:0] kill_hit, kill_new, eligible, grant, load;
  logic [3:0] pick_gnt0, pick_gnt1;
  logic       pick_vld0, pick_vld1, vld1;
  logic [1:0] idx0, idx1;

`ifdef WB_ARBITER_KILL_EN
  logic [WIDTH_BRM-1:0] buf_brm_q [4];
  logic [WIDTH_BRM-1:0] buf_brm_d [4];

  always_comb begin
    kill_hit = 4'b0000;
    kill_new = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      kill_hit[k] = i_kill[WIDTH_BRM] & (|(buf_brm_q[k] & i_kill[WIDTH_BRM-1:0]));
      kill_new[k] = i_kill[WIDTH_BRM]
                  & (|(i_req_brmask[k*WIDTH_BRM +: WIDTH_BRM] & i_kill[WIDTH_BRM-1:0]));
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      buf_brm_d[k] = load[k] ? i_req_brmask[k*WIDTH_BRM +: WIDTH_BRM] : buf_brm_q[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 4; k++) buf_brm_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) buf_brm_q[k] <= buf_brm_d[k];
    end
  end
`else
  // Branch masks only matter for kill; without it they are dropped at the port.
  logic unused_kill;
  assign unused_kill = (^i_kill) ^ (^i_req_brmask);
  assign kill_hit    = 4'b0000;
  assign kill_new    = 4'b0000;
`endif

  assign eligible = buf_valid_q & ~kill_hit;

  rr_pick2 u_pick (
    .i_req  (eligible),
    .i_ptr  (rr_ptr_q),
    .o_gnt0 (pick_gnt0),
    .o_gnt1 (pick_gnt1),
    .o_vld0 (pick_vld0),
    .o_vld1 (pick_vld1)
  );

  assign idx0 = onehot4_to_idx(pick_gnt0);
  assign idx1 = onehot4_to_idx(pick_gnt1);
  // Two writes to the same prd in one cycle would race in the regfile; keep the first.
  assign vld1  = pick_vld1 & (buf_prd_q[idx1] != buf_prd_q[idx0]);
  assign grant = pick_gnt0 | (vld1 ? pick_gnt1 : 4'b0000);

  assign o_req_ready = ~buf_valid_q | grant;
  assign o_busy      = |buf_valid_q;

  always_comb begin
    load = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      load[k] = i_req_valid[k] & o_req_ready[k]
              & (|i_req_prd[k*WIDTH_PRD +: WIDTH_PRD]) & ~kill_new[k];
    end
  end

  always_comb begin
    buf_valid_d = (buf_valid_q & ~grant & ~kill_hit) | load;
    for (int k = 0; k < 4; k++) begin
      buf_prd_d[k]  = load[k] ? i_req_prd[k*WIDTH_PRD +: WIDTH_PRD]    : buf_prd_q[k];
      buf_data_d[k] = load[k] ? i_req_data[k*WIDTH_DATA +: WIDTH_DATA] : buf_data_q[k];
    end
  end

  always_comb begin
    we_d    = {vld1, pick_vld0};
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wdest_d = '0;
    if (pick_vld0) begin
      waddr_d[0 +: WIDTH_PRD]  = buf_prd_q[idx0];
      wdata_d[0 +: WIDTH_DATA] = buf_data_q[idx0];
      wdest_d[0 +: WIDTH_PRD]  = buf_prd_q[idx0];
    end
    if (vld1) begin
      waddr_d[WIDTH_PRD +: WIDTH_PRD]   = buf_prd_q[idx1];
      wdata_d[WIDTH_DATA +: WIDTH_DATA] = buf_data_q[idx1];
      wdest_d[WIDTH_PRD +: WIDTH_PRD]   = buf_prd_q[idx1];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (vld1)           rr_ptr_d = idx1 + 2'd1;
    else if (pick_vld0) rr_ptr_d = idx0 + 2'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_valid_q <= 4'b0000;
      rr_ptr_q    <= 2'd0;
      we_q        <= 2'b00;
      waddr_q     <= '0;
      wdata_q     <= '0;
      wdest_q     <= '0;
      for (int k = 0; k < 4; k++) begin
        buf_prd_q[k]  <= '0;
        buf_data_q[k] <= '0;
      end
    end else begin
      buf_valid_q <= buf_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      wdest_q     <= wdest_d;
      for (int k = 0; k < 4; k++) begin
        buf_prd_q[k]  <= buf_prd_d[k];
        buf_data_q[k] <= buf_data_d[k];
      end
    end
  end

  assign o_we      = we_q;
  assign o_waddr   = waddr_q;
  assign o_wdata   = wdata_q;
  assign o_wdest2x = wdest_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_wb_arbiter -- directed bench with a cycle-level reference model.
// Revision: 1.0
// ============================================================================
module tb_wb_arbiter;

  localparam int WP = 7;
  localparam int WB = 3;
  localparam int WD = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic [3:0]    req_v;
  logic [WP-1:0] req_prd  [4];
  logic [WD-1:0] req_data [4];
  logic [WB-1:0] req_brm  [4];
  logic [WB:0]   kill;

  logic [4*WP-1:0] tb_prd;
  logic [4*WD-1:0] tb_data;
  logic [4*WB-1:0] tb_brm;

  logic [3:0]      o_req_ready;
  logic [1:0]      o_we;
  logic [2*WP-1:0] o_waddr;
  logic [2*WD-1:0] o_wdata;
  logic [2*WP-1:0] o_wdest2x;
  logic            o_busy;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    tb_prd  = '0;
    tb_data = '0;
    tb_brm  = '0;
    for (int k = 0; k < 4; k++) begin
      tb_prd[k*WP +: WP]  = req_prd[k];
      tb_data[k*WD +: WD] = req_data[k];
      tb_brm[k*WB +: WB]  = req_brm[k];
    end
  end

  wb_arbiter #(.WIDTH_PRD(WP), .WIDTH_BRM(WB), .WIDTH_DATA(WD)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_v),
    .i_req_prd    (tb_prd),
    .i_req_data   (tb_data),
    .i_req_brmask (tb_brm),
    .o_req_ready  (o_req_ready),
    .i_kill       (kill),
    .o_we         (o_we),
    .o_waddr      (o_waddr),
    .o_wdata      (o_wdata),
    .o_wdest2x    (o_wdest2x),
    .o_busy       (o_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit            m_valid [4];
  logic [WP-1:0] m_prd   [4];
  logic [WD-1:0] m_data  [4];
  logic [WB-1:0] m_brm   [4];
  int            m_ptr;
  logic [1:0]    m_we;
  logic [WP-1:0] m_waddr [2];
  logic [WD-1:0] m_wdata [2];
  logic [WP-1:0] m_wdest [2];

  function automatic bit m_killed(input logic [WB-1:0] brm);
`ifdef WB_ARBITER_KILL_EN
    return kill[WB] && ((brm & kill[WB-1:0]) != 0);
`else
    return (brm == brm) && 1'b0;
`endif
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < 4; k++) begin
      m_valid[k] = 0; m_prd[k] = '0; m_data[k] = '0; m_brm[k] = '0;
    end
    m_ptr = 0;
    m_we  = 2'b00;
    for (int p = 0; p < 2; p++) begin
      m_waddr[p] = '0; m_wdata[p] = '0; m_wdest[p] = '0;
    end
  endfunction

  // Walk the requesters in rotating order from the pointer; take the first two live ones.
  function automatic void m_pick(output int g0, output int g1);
    g0 = -1;
    g1 = -1;
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (m_ptr + i) % 4;
      if (m_valid[j] && !m_killed(m_brm[j])) begin
        if (g0 < 0)      g0 = j;
        else if (g1 < 0) g1 = j;
      end
    end
    if (g1 >= 0 && m_prd[g1] == m_prd[g0]) g1 = -1;
  endfunction

  function automatic logic [3:0] m_ready();
    int g0, g1;
    logic [3:0] r;
    m_pick(g0, g1);
    for (int k = 0; k < 4; k++) r[k] = !m_valid[k] || k == g0 || k == g1;
    return r;
  endfunction

  function automatic void m_step();
    int g0, g1;
    logic [3:0] rdy;
    m_pick(g0, g1);
    rdy  = m_ready();
    m_we = {g1 >= 0, g0 >= 0};
    m_wdest[0] = '0;
    m_wdest[1] = '0;
    if (g0 >= 0) begin
      m_waddr[0] = m_prd[g0]; m_wdata[0] = m_data[g0]; m_wdest[0] = m_prd[g0];
    end
    if (g1 >= 0) begin
      m_waddr[1] = m_prd[g1]; m_wdata[1] = m_data[g1]; m_wdest[1] = m_prd[g1];
    end
    for (int k = 0; k < 4; k++) begin
      if (k == g0 || k == g1 || (m_valid[k] && m_killed(m_brm[k]))) m_valid[k] = 0;
    end
    for (int k = 0; k < 4; k++) begin
      if (req_v[k] && rdy[k] && req_prd[k] != 0 && !m_killed(req_brm[k])) begin
        m_valid[k] = 1; m_prd[k] = req_prd[k]; m_data[k] = req_data[k]; m_brm[k] = req_brm[k];
      end
    end
    if (g1 >= 0)      m_ptr = (g1 + 1) % 4;
    else if (g0 >= 0) m_ptr = (g0 + 1) % 4;
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_step();
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    forever begin
      logic busy;
      @(negedge clk);
      busy = 1'b0;
      for (int k = 0; k < 4; k++) busy = busy | m_valid[k];
      chk("ready", 64'(o_req_ready), 64'(m_ready()));
      chk("busy",  64'(o_busy),      64'(busy));
      chk("we",    64'(o_we),        64'(m_we));
      chk("waddr", 64'(o_waddr),     64'({m_waddr[1], m_waddr[0]}));
      chk("wdata", 64'(o_wdata),     64'({m_wdata[1], m_wdata[0]}));
      chk("wdest", 64'(o_wdest2x),   64'({m_wdest[1], m_wdest[0]}));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    req_v = 4'b0000;
    kill  = '0;
    for (int k = 0; k < 4; k++) begin
      req_prd[k] = '0; req_data[k] = '0; req_brm[k] = '0;
    end
  endtask

  task automatic put(input int k, input logic [WP-1:0] prd, input logic [WD-1:0] data,
                     input logic [WB-1:0] brm);
    req_v[k] = 1'b1; req_prd[k] = prd; req_data[k] = data; req_brm[k] = brm;
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    clear_in();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", 64'(o_req_ready), 64'h0f);
    chk("rst_busy",  64'(o_busy),      64'h0);
    chk("rst_we",    64'(o_we),        64'h0);
    chk("rst_waddr", 64'(o_waddr),     64'h0);
    chk("rst_wdest", 64'(o_wdest2x),   64'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single MEM result
    put(0, 7'd5, 32'hDEADBEEF, 3'b000);
    tick();
    clear_in();
    tick();
    chk("single_we",    64'(o_we),            64'h1);
    chk("single_waddr", 64'(o_waddr),         64'({7'd0, 7'd5}));
    chk("single_wdata", 64'(o_wdata[WD-1:0]), 64'hDEADBEEF);
    chk("single_wdest", 64'(o_wdest2x),       64'({7'd0, 7'd5}));
    tick();
    chk("single_we_off",  64'(o_we),      64'h0);
    chk("single_wdest_0", 64'(o_wdest2x), 64'h0);

    // All four requesters at once from pointer 0
    do_reset();
    for (int k = 0; k < 4; k++) put(k, 7'(k + 1), 32'(32'h1000 * (k + 1)), 3'b000);
    tick();
    clear_in();
    tick();
    chk("all4_c1_we",    64'(o_we),    64'h3);
    chk("all4_c1_waddr", 64'(o_waddr), 64'({7'd2, 7'd1}));
    chk("all4_c1_wdata", 64'(o_wdata), {32'h2000, 32'h1000});
    tick();
    chk("all4_c2_waddr", 64'(o_waddr), 64'({7'd4, 7'd3}));
    chk("all4_c2_wdata", 64'(o_wdata), {32'h4000, 32'h3000});
    tick();
    chk("all4_idle_we", 64'(o_we), 64'h0);

    // ALU1 streaming one result per cycle
    for (int i = 0; i < 8; i++) begin
      put(2, 7'(10 + i), 32'(32'hA0 + i), 3'b000);
      tick();
      chk("stream_ready2", 64'(o_req_ready[2]), 64'h1);
      if (i > 0) begin
        chk("stream_we",    64'(o_we),            64'h1);
        chk("stream_waddr", 64'(o_waddr[WP-1:0]), 64'(10 + i - 1));
      end
    end
    clear_in();
    tick();
    chk("stream_last", 64'(o_waddr[WP-1:0]), 64'd17);
    tick();
    chk("stream_done", 64'(o_we), 64'h0);

    // prd 0 results are discarded
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) put(k, 7'd0, 32'hFFFF_FFFF, 3'b000);
      tick();
      chk("p0_busy",  64'(o_busy),      64'h0);
      chk("p0_we",    64'(o_we),        64'h0);
      chk("p0_ready", 64'(o_req_ready), 64'hf);
    end
    clear_in();
    tick();

    // Two buffered results with the same prd
    do_reset();
    put(0, 7'd9, 32'hAAAA, 3'b000);
    put(1, 7'd9, 32'hBBBB, 3'b000);
    put(2, 7'd6, 32'hCCCC, 3'b000);
    tick();
    clear_in();
    tick();
    chk("dup_c1_we",    64'(o_we),            64'h1);
    chk("dup_c1_waddr", 64'(o_waddr[WP-1:0]), 64'd9);
    chk("dup_c1_wdata", 64'(o_wdata[WD-1:0]), 64'hAAAA);
    tick();
    chk("dup_c2_we",    64'(o_we),    64'h3);
    chk("dup_c2_waddr", 64'(o_waddr), 64'({7'd6, 7'd9}));
    chk("dup_c2_wdata", 64'(o_wdata), {32'hCCCC, 32'hBBBB});
    tick();

    // Branch kill on a buffered ALU1 result and on a fresh MEM handshake
    do_reset();
    put(0, 7'd1, 32'h100, 3'b001);
    put(1, 7'd2, 32'h200, 3'b001);
    put(2, 7'd3, 32'h300, 3'b010);
    put(3, 7'd4, 32'h400, 3'b100);
    tick();
    clear_in();
    kill = {1'b1, 3'b010};
    put(0, 7'd20, 32'h2000, 3'b010);
    put(1, 7'd21, 32'h2100, 3'b001);
    tick();
    chk("kill_c1_we",    64'(o_we),    64'h3);
    chk("kill_c1_waddr", 64'(o_waddr), 64'({7'd2, 7'd1}));
    clear_in();
    tick();
`ifdef WB_ARBITER_KILL_EN
    chk("kill_c2_waddr", 64'(o_waddr), 64'({7'd21, 7'd4}));
    chk("kill_c2_wdata", 64'(o_wdata), {32'h2100, 32'h400});
    tick();
    chk("kill_c3_we", 64'(o_we), 64'h0);
`else
    chk("nokill_c2_waddr", 64'(o_waddr), 64'({7'd4, 7'd3}));
    tick();
    chk("nokill_c3_waddr", 64'(o_waddr), 64'({7'd21, 7'd20}));
    tick();
    chk("nokill_c4_we", 64'(o_we), 64'h0);
`endif
    tick();

    // Mixed traffic with back-pressure, zero prds, repeats and kills
    for (int c = 0; c < 24; c++) begin
      clear_in();
      for (int k = 0; k < 4; k++) begin
        if (((c + k) % 3) != 0)
          put(k, 7'((c * 5 + k * 3) % 16), 32'(c * 256 + k), 3'(1 << (k % 3)));
      end
      kill = {((c % 5) == 0), 3'(c % 8)};
      tick();
    end
    clear_in();
    repeat (4) tick();

    // Reset in the middle of a busy cycle
    for (int k = 0; k < 4; k++) put(k, 7'(31 + k), 32'(32'h5000 + k), 3'b000);
    tick();
    for (int k = 0; k < 4; k++) put(k, 7'(41 + k), 32'(32'h6000 + k), 3'b000);
    tick();
    tick();
    chk("pre_rst_we", 64'(o_we), 64'h3);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_we",    64'(o_we),        64'h0);
    chk("mid_rst_waddr", 64'(o_waddr),     64'h0);
    chk("mid_rst_wdata", 64'(o_wdata),     64'h0);
    chk("mid_rst_wdest", 64'(o_wdest2x),   64'h0);
    chk("mid_rst_busy",  64'(o_busy),      64'h0);
    chk("mid_rst_ready", 64'(o_req_ready), 64'hf);
    clear_in();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_we", 64'(o_we), 64'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
